// File: rtl/fifo_ctrl_pkg.sv
//==============================================================================
// fifo_ctrl_pkg: constants shared by the 8x17 FIFO wrapper and its access controller
// Rev 1.0
//==============================================================================
`default_nettype none

package fifo_ctrl_pkg;

  localparam int FIFO_DATA_W = 17;
  localparam int FIFO_DEPTH  = 8;

  // Width needed to count 0..depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int FIFO_LEVEL_W = level_width(FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/fifo_access_ctrl_if.sv
//==============================================================================
// fifo_access_ctrl_if: producer, FIFO-pin and consumer signals of the access controller
// Rev 1.0
//==============================================================================
`default_nettype none

interface fifo_access_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
);

  localparam int LEVEL_W = level_width(DEPTH);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_push;
  logic [DATA_W-1:0]       fifo_din;
  logic                    fifo_full;
  logic                    fifo_pull;
  logic                    fifo_empty;
  logic [DATA_W-1:0]       fifo_dout;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [LEVEL_W-1:0]      level;
  logic                    overflow_err;

  // Environment side: producers, the FIFO and the consumer.
  modport master (
    output req_valid, req_data, fifo_full, fifo_empty, fifo_dout, out_ready,
    input  req_ready, fifo_push, fifo_din, fifo_pull, out_valid, out_data,
           level, overflow_err
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_empty, fifo_dout, out_ready,
    output req_ready, fifo_push, fifo_din, fifo_pull, out_valid, out_data,
           level, overflow_err
  );

endinterface

`default_nettype wire

// File: rtl/fifo_access_ctrl_rr_arbiter.sv
//==============================================================================
// rr_arbiter: combinational round-robin grant starting at ptr; pointer register lives in parent
// Rev 1.0
//==============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] winner,
  output logic [PTR_W-1:0] next_ptr,
  output logic             any
);

  // Modulo-N_REQ add; one spare bit so the sum never wraps before the compare.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + (PTR_W+1)'(b);
    if (s >= (PTR_W+1)'(N_REQ)) begin
      s = s - (PTR_W+1)'(N_REQ);
    end
    return s[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant    = '0;
    winner   = '0;
    any      = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = wrap_add(ptr, k);
      if (en && !any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
    if (any) begin
      grant[winner] = 1'b1;
    end
    next_ptr = any ? wrap_add(winner, 1) : ptr;
  end

endmodule

`default_nettype wire

// File: rtl/fifo_access_ctrl.sv
//==============================================================================
// fifo_access_ctrl: round-robin push arbitration, valid/ready drain and shadow level for the shared FIFO
// Rev 1.0
//==============================================================================
`default_nettype none

module fifo_access_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_access_ctrl_if.slave    bus
);

  localparam int               PTR_W     = $clog2(N_REQ);
  localparam int               LEVEL_W   = level_width(DEPTH);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(DEPTH);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   winner;
  logic [N_REQ-1:0]   grant;
  logic               push;
  logic               pull;
  logic               out_valid_q;
  logic [LEVEL_W-1:0] level_q;
  logic               overflow_q;

  // Grants are suppressed during reset so held requests wait for the first free cycle.
  rr_arbiter #(
    .N_REQ    (N_REQ)
  ) u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr),
    .en       (!rst && !bus.fifo_full),
    .grant    (grant),
    .winner   (winner),
    .next_ptr (next_ptr),
    .any      (push)
  );

  assign bus.req_ready = grant;
  assign bus.fifo_push = push;
  assign bus.fifo_din  = bus.req_data[winner*DATA_W +: DATA_W];

  // The FIFO output register is the consumer data register; pull whenever that slot frees up.
  assign pull          = !rst && !bus.fifo_empty && (!out_valid_q || bus.out_ready);
  assign bus.fifo_pull = pull;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = bus.fifo_dout;
  assign bus.level     = level_q;
  assign bus.overflow_err = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= next_ptr;
      end
      if (pull) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Out-of-range moves are flagged and the count saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      case ({push, pull})
        2'b10: begin
          if (level_q == LEVEL_MAX) begin
            overflow_q <= 1'b1;
          end else begin
            level_q <= level_q + LEVEL_W'(1);
          end
        end
        2'b01: begin
          if (level_q == '0) begin
            overflow_q <= 1'b1;
          end else begin
            level_q <= level_q - LEVEL_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_access_ctrl.sv
//==============================================================================
// tb_fifo_access_ctrl: directed scenarios against a behavioural 8x17 FIFO model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_fifo_access_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int DW = FIFO_DATA_W;
  localparam int DP = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fake_empty = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fifo_access_ctrl_if #(.N_REQ(N), .DATA_W(DW), .DEPTH(DP)) bus ();

  fifo_access_ctrl #(.N_REQ(N), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural FIFO: registered data_out, flags derived from a registered count.
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] m_dout;
  int            cnt, rd, wr;
  wire           m_push = bus.fifo_push && (cnt < DP);
  wire           m_pull = bus.fifo_pull && (cnt > 0);

  always @(posedge clk) begin
    if (rst) begin
      cnt    <= 0;
      rd     <= 0;
      wr     <= 0;
      m_dout <= '0;
    end else begin
      if (m_push) begin
        mem[wr] <= bus.fifo_din;
        wr      <= (wr + 1) % DP;
      end
      if (m_pull) begin
        m_dout <= mem[rd];
        rd     <= (rd + 1) % DP;
      end
      cnt <= cnt + int'(m_push) - int'(m_pull);
    end
  end

  assign bus.fifo_full  = (cnt == DP);
  assign bus.fifo_empty = (cnt == 0) && !fake_empty;
  assign bus.fifo_dout  = m_dout;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [DW-1:0] v);
    bus.req_data[p*DW +: DW] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    fake_empty    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    fake_empty    = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL rst_push got=%b exp=0", bus.fifo_push); end
    checks++; if (bus.fifo_pull !== 1'b0) begin failures++; $display("FAIL rst_pull got=%b exp=0", bus.fifo_pull); end
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", bus.level); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", bus.overflow_err); end
    checks++; if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL rst_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    fake_empty = 1'b0;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.req_valid = 4'b1111;
    for (int p = 0; p < N; p++) set_port(p, DW'(32'h100 + p));
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'(1 << (c % 4))) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4))); end
      checks++; if (bus.fifo_din !== DW'(32'h100 + (c % 4))) begin failures++; $display("FAIL rr_din c=%0d got=%h exp=%h", c, bus.fifo_din, 32'h100 + (c % 4)); end
      tick();
      if (c == 7) begin
        checks++; if (bus.level !== 4'd7) begin failures++; $display("FAIL rr_level8push got=%0d exp=7", bus.level); end
      end
    end
    @(negedge clk);
    checks++; if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL rr_full got=%b exp=1", bus.fifo_full); end
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rr_full_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.fifo_push !== 1'b0) begin failures++; $display("FAIL rr_full_push got=%b exp=0", bus.fifo_push); end
    checks++; if (bus.level !== 4'd8) begin failures++; $display("FAIL rr_full_level got=%0d exp=8", bus.level); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 17'h100) begin failures++; $display("FAIL rr_head got=%b/%h exp=1/100", bus.out_valid, bus.out_data); end
    tick();
  endtask

  task automatic test_single_port_stream();
    apply_reset();
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      if (k == 6) bus.req_valid = 4'b0000;
      set_port(2, DW'(32'h200 + k));
      @(negedge clk);
      if (k < 6) begin
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL sp_grant k=%0d got=%b exp=0100", k, bus.req_ready); end
      end
      if (k >= 2) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(32'h200 + k - 2)) begin failures++; $display("FAIL sp_out k=%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_data, 32'h200 + k - 2); end
      end
      tick();
      if (k < 6) begin
        checks++; if (dut.rr_ptr !== 2'd3) begin failures++; $display("FAIL sp_rr_ptr k=%0d got=%0d exp=3", k, dut.rr_ptr); end
        checks++; if (bus.level !== 4'd1) begin failures++; $display("FAIL sp_level k=%0d got=%0d exp=1", k, bus.level); end
      end
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 4'd0) begin failures++; $display("FAIL sp_drained got=%b/%0d exp=0/0", bus.out_valid, bus.level); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] words [3] = '{17'h0A1, 17'h0B2, 17'h0C3};
    logic          rdy   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [DW-1:0] exp_d [5] = '{17'h0A1, 17'h0B2, 17'h0B2, 17'h0B2, 17'h0C3};
    apply_reset();
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      set_port(0, words[i]);
      tick();
    end
    bus.req_valid = 4'b0000;
    checks++; if (bus.level !== 4'd2 || bus.out_valid !== 1'b1 || bus.out_data !== 17'h0A1) begin failures++; $display("FAIL st_loaded got=%0d/%b/%h exp=2/1/0a1", bus.level, bus.out_valid, bus.out_data); end
    for (int s = 0; s < 5; s++) begin
      bus.out_ready = rdy[s];
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[s]) begin failures++; $display("FAIL st_out s=%0d got=%b/%h exp=1/%h", s, bus.out_valid, bus.out_data, exp_d[s]); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 4'd0) begin failures++; $display("FAIL st_end got=%b/%0d exp=0/0", bus.out_valid, bus.level); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w [6] = '{17'h300, 17'h311, 17'h322, 17'h333, 17'h340, 17'h351};
    int idx = 0;
    apply_reset();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < N; p++) set_port(p, DW'(32'h300 + 16 * c + p));
      if (c == 5) bus.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'(1 << (c % 4))) begin failures++; $display("FAIL bb_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'(1 << (c % 4))); end
      if (c == 5) begin
        checks++; if (bus.fifo_push !== 1'b1 || bus.fifo_pull !== 1'b1) begin failures++; $display("FAIL bb_both got=%b%b exp=11", bus.fifo_push, bus.fifo_pull); end
        checks++; if (bus.out_data !== exp_w[idx]) begin failures++; $display("FAIL bb_order i=%0d got=%h exp=%h", idx, bus.out_data, exp_w[idx]); end
        idx++;
      end
      tick();
      if (c >= 4) begin
        checks++; if (bus.level !== 4'd4) begin failures++; $display("FAIL bb_level c=%0d got=%0d exp=4", c, bus.level); end
      end
    end
    bus.req_valid = 4'b0000;
    for (int t = 0; t < 12 && idx < 6; t++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        checks++; if (bus.out_data !== exp_w[idx]) begin failures++; $display("FAIL bb_order i=%0d got=%h exp=%h", idx, bus.out_data, exp_w[idx]); end
        idx++;
      end
      tick();
    end
    checks++; if (idx !== 6) begin failures++; $display("FAIL bb_count got=%0d exp=6", idx); end
    checks++; if (bus.out_valid !== 1'b0 || bus.level !== 4'd0) begin failures++; $display("FAIL bb_end got=%b/%0d exp=0/0", bus.out_valid, bus.level); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_g [3] = '{4'b1000, 4'b0010, 4'b1000};
    logic [1:0] exp_p [3] = '{2'd0, 2'd2, 2'd0};
    apply_reset();
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b0010;
    set_port(1, 17'h011);
    tick();
    checks++; if (dut.rr_ptr !== 2'd2) begin failures++; $display("FAIL wr_setup_ptr got=%0d exp=2", dut.rr_ptr); end
    bus.req_valid = 4'b1010;
    set_port(1, 17'h021);
    set_port(3, 17'h023);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.req_ready !== exp_g[i]) begin failures++; $display("FAIL wr_grant i=%0d got=%b exp=%b", i, bus.req_ready, exp_g[i]); end
      if (i == 0) begin
        checks++; if (bus.fifo_din !== 17'h023) begin failures++; $display("FAIL wr_din got=%h exp=023", bus.fifo_din); end
      end
      tick();
      checks++; if (dut.rr_ptr !== exp_p[i]) begin failures++; $display("FAIL wr_ptr i=%0d got=%0d exp=%0d", i, dut.rr_ptr, exp_p[i]); end
    end
    bus.req_valid = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req_valid = 4'b0001;
    set_port(0, 17'h055);
    repeat (6) tick();
    checks++; if (bus.level !== 4'd5 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rm_setup got=%0d/%b exp=5/1", bus.level, bus.out_valid); end
    bus.req_valid = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rm_in_rst_ready got=%b exp=0000", bus.req_ready); end
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.level !== 4'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", bus.level); end
    checks++; if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL rm_rr_ptr got=%0d exp=0", dut.rr_ptr); end
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rm_first_grant got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_underflow();
    apply_reset();
    fake_empty = 1'b1;
    @(negedge clk);
    checks++; if (bus.fifo_pull !== 1'b1) begin failures++; $display("FAIL uf_pull got=%b exp=1", bus.fifo_pull); end
    tick();
    fake_empty = 1'b0;
    checks++; if (bus.overflow_err !== 1'b1 || bus.level !== 4'd0) begin failures++; $display("FAIL uf_flag got=%b/%0d exp=1/0", bus.overflow_err, bus.level); end
    tick();
    checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", bus.overflow_err); end
    apply_reset();
    checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL uf_cleared got=%b exp=0", bus.overflow_err); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_single_port_stream();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
